conv_window_scheduler: RTL and testbench

- Sequences the 5x5 convolution datapath for one IX x IY single-channel frame.
- Accepts the pixel stream and drives the line-buffer shift enable.
- Detects complete KX x KY windows and time-multiplexes one shared MAC across CO output channels.
- Tags each MAC result with channel and output coordinates, and pulses done after the frame's last result.

---
 rtl/conv_sched_pkg.sv | 29 ++
 rtl/conv_sched_if.sv | 32 +++
 rtl/conv_tag_pipe.sv | 26 ++
 rtl/conv_window_scheduler.sv | 156 +++++++++++++++
 tb/tb_conv_window_scheduler.sv | 383 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/conv_sched_pkg.sv
// Shared types and default geometry for the 5x5 convolution window scheduler.
// Imported by the interface, the tag pipeline and the top.
package conv_sched_pkg;

    localparam int DEF_IX = 28;
    localparam int DEF_IY = 28;
    localparam int DEF_KX = 5;
    localparam int DEF_KY = 5;
    localparam int DEF_CO = 3;

    localparam int XW_D = $clog2(DEF_IX);
    localparam int YW_D = $clog2(DEF_IY);
    localparam int CW_D = (DEF_CO > 1) ? $clog2(DEF_CO) : 1;

    typedef enum logic [1:0] {
        ACCEPT,
        ISSUE,
        DRAIN,
        DONE
    } state_e;

    typedef struct packed {
        logic            valid;
        logic [CW_D-1:0] ch;
        logic [XW_D-1:0] x;
        logic [YW_D-1:0] y;
    } tag_t;

endpackage

// File: rtl/conv_sched_if.sv
// Pixel handshake, MAC issue and tagged-result bundle of the scheduler.
// The scheduler uses the slave side; the pixel source / sink uses master.
interface conv_sched_if
    import conv_sched_pkg::*;
#(
    parameter int XW = XW_D,
    parameter int YW = YW_D,
    parameter int CW = CW_D
);
    logic          i_valid;
    logic          o_ready;
    logic          o_lb_shift;
    logic          o_issue;
    logic [CW-1:0] o_ch_sel;
    logic          o_res_valid;
    logic [CW-1:0] o_res_ch;
    logic [XW-1:0] o_res_x;
    logic [YW-1:0] o_res_y;
    logic          o_done;

    modport master (
        output i_valid,
        input  o_ready, o_lb_shift, o_issue, o_ch_sel,
        input  o_res_valid, o_res_ch, o_res_x, o_res_y, o_done
    );

    modport slave (
        input  i_valid,
        output o_ready, o_lb_shift, o_issue, o_ch_sel,
        output o_res_valid, o_res_ch, o_res_x, o_res_y, o_done
    );
endinterface

// File: rtl/conv_tag_pipe.sv
// Fixed-latency tag shift register that tracks MAC ops in flight.
// Synchronous clear drops every in-flight tag.
module conv_tag_pipe
    import conv_sched_pkg::*;
#(
    parameter int  LAT = 3,
    parameter type T   = tag_t
) (
    input  logic clk,
    input  logic clr_i,
    input  T     tag_i,
    output T     tag_o
);
    T pipe_q [LAT];

    always_ff @(posedge clk) begin
        if (clr_i) begin
            for (int i = 0; i < LAT; i++) pipe_q[i] <= '0;
        end else begin
            pipe_q[0] <= tag_i;
            for (int i = 1; i < LAT; i++) pipe_q[i] <= pipe_q[i-1];
        end
    end

    assign tag_o = pipe_q[LAT-1];
endmodule

// File: rtl/conv_window_scheduler.sv
// Frame sequencer for the 5x5 conv datapath: pixel accept, window
// detection, CO-way MAC time multiplexing and result tagging.
module conv_window_scheduler
    import conv_sched_pkg::*;
#(
    parameter int IX      = DEF_IX,
    parameter int IY      = DEF_IY,
    parameter int KX      = DEF_KX,
    parameter int KY      = DEF_KY,
    parameter int CO      = DEF_CO,
    parameter int MAC_LAT = 3,
    parameter int XW      = $clog2(IX),
    parameter int YW      = $clog2(IY),
    parameter int CW      = (CO > 1) ? $clog2(CO) : 1
) (
    input logic         clk,
    input logic         reset,
    conv_sched_if.slave bus
);
    localparam int DW = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;

    localparam logic [XW-1:0] COL_LAST = XW'(IX - 1);
    localparam logic [YW-1:0] ROW_LAST = YW'(IY - 1);
    localparam logic [XW-1:0] KX_M1    = XW'(KX - 1);
    localparam logic [YW-1:0] KY_M1    = YW'(KY - 1);
    localparam logic [CW-1:0] CH_LAST  = CW'(CO - 1);
    localparam logic [DW-1:0] DRN_LAST = DW'(MAC_LAT - 1);

    typedef struct packed {
        logic          valid;
        logic [CW-1:0] ch;
        logic [XW-1:0] x;
        logic [YW-1:0] y;
    } tag_lt;

    state_e        state_q, state_d;
    logic [XW-1:0] col_q, col_d;
    logic [YW-1:0] row_q, row_d;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic          last_q, last_d;
    logic [CW-1:0] ch_q, ch_d;
    logic [DW-1:0] drn_q, drn_d;
    logic          accept;
    logic          win_hit;
    tag_lt         tag_in;
    tag_lt         tag_out;

    assign bus.o_ready    = (state_q == ACCEPT);
    assign accept         = bus.i_valid & bus.o_ready;
    assign bus.o_lb_shift = accept;
    assign win_hit        = (row_q >= KY_M1) && (col_q >= KX_M1);

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (accept) begin
            if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = (row_q == ROW_LAST) ? '0 : row_q + YW'(1);
            end else begin
                col_d = col_q + XW'(1);
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        x_d          = x_q;
        y_d          = y_q;
        last_d       = last_q;
        ch_d         = ch_q;
        drn_d        = drn_q;
        bus.o_issue  = 1'b0;
        bus.o_ch_sel = '0;
        bus.o_done   = 1'b0;
        unique case (state_q)
            ACCEPT: begin
                if (accept && win_hit) begin
                    state_d = ISSUE;
                    x_d     = col_q - KX_M1;
                    y_d     = row_q - KY_M1;
                    last_d  = (row_q == ROW_LAST) && (col_q == COL_LAST);
                    ch_d    = '0;
                end
            end
            ISSUE: begin
                bus.o_issue  = 1'b1;
                bus.o_ch_sel = ch_q;
                if (ch_q == CH_LAST) begin
                    ch_d    = '0;
                    drn_d   = '0;
                    state_d = last_q ? DRAIN : ACCEPT;
                end else begin
                    ch_d = ch_q + CW'(1);
                end
            end
            DRAIN: begin
                if (drn_q == DRN_LAST) state_d = DONE;
                else drn_d = drn_q + DW'(1);
            end
            DONE: begin
                bus.o_done = 1'b1;
                state_d    = ACCEPT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ACCEPT;
            col_q   <= '0;
            row_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            last_q  <= 1'b0;
            ch_q    <= '0;
            drn_q   <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            x_q     <= x_d;
            y_q     <= y_d;
            last_q  <= last_d;
            ch_q    <= ch_d;
            drn_q   <= drn_d;
        end
    end

    // Idle slots carry an all-zero tag so o_res_* stay quiet between results.
    always_comb begin
        tag_in       = '0;
        tag_in.valid = bus.o_issue;
        if (bus.o_issue) begin
            tag_in.ch = bus.o_ch_sel;
            tag_in.x  = x_q;
            tag_in.y  = y_q;
        end
    end

    conv_tag_pipe #(
        .LAT (MAC_LAT),
        .T   (tag_lt)
    ) u_tag_pipe (
        .clk   (clk),
        .clr_i (reset),
        .tag_i (tag_in),
        .tag_o (tag_out)
    );

    assign bus.o_res_valid = tag_out.valid;
    assign bus.o_res_ch    = tag_out.ch;
    assign bus.o_res_x     = tag_out.x;
    assign bus.o_res_y     = tag_out.y;
endmodule

// File: tb/tb_conv_window_scheduler.sv
// Directed bench for conv_window_scheduler: frame counts, window timing,
// row boundaries, stalls, mid-frame reset and back-to-back frames.
module tb_conv_window_scheduler;
    import conv_sched_pkg::*;

    localparam int MAC_LAT = 3;
    localparam int NX      = DEF_IX - DEF_KX + 1;
    localparam int NY      = DEF_IY - DEF_KY + 1;
    localparam int NPF     = NX * NY * DEF_CO;
    localparam int NPIX    = DEF_IX * DEF_IY;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    conv_sched_if bus ();

    conv_window_scheduler #(
        .MAC_LAT (MAC_LAT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    int cyc = 0;
    int n_shift, n_iss, n_res, n_done;
    int bad_tag, bad_lat, bad_acc;
    int last_iss_cyc, done_cyc, d1_cyc, acc_after_done;
    int trig_p;
    bit after_acc;
    int f2_ch, f2_x, f2_y;
    int iss_cyc [4096];
    int iss_pix [4096];
    bit px_iss  [NPIX];
    int px_x    [NPIX];
    int px_y    [NPIX];

    function automatic logic [18:0] outs();
        return {bus.o_ready, bus.o_lb_shift, bus.o_issue, bus.o_ch_sel,
                bus.o_res_valid, bus.o_res_ch, bus.o_res_x, bus.o_res_y,
                bus.o_done};
    endfunction

    task automatic mon_clear();
        n_shift = 0; n_iss = 0; n_res = 0; n_done = 0;
        bad_tag = 0; bad_lat = 0; bad_acc = 0;
        last_iss_cyc = -1; done_cyc = -1; d1_cyc = -1;
        acc_after_done = -1; trig_p = -1; after_acc = 0;
        f2_ch = -1; f2_x = -1; f2_y = -1;
        for (int i = 0; i < NPIX; i++) begin
            px_iss[i] = 0; px_x[i] = -1; px_y[i] = -1;
        end
    endtask

    // One clock: drive at negedge, observe 1 ns later and update the monitor.
    task automatic step(input logic v, input logic r);
        int idx;
        int p;
        @(negedge clk);
        reset = r;
        bus.i_valid = v;
        #1;
        cyc++;
        if (!r) begin
            if (bus.o_lb_shift !== (bus.i_valid & bus.o_ready)) bad_acc++;
            if (after_acc && trig_p >= 0) px_iss[trig_p] = bus.o_issue;
            if (bus.o_issue) begin
                idx = n_iss % NPF;
                if (bus.o_ch_sel !== CW_D'(idx % DEF_CO)) bad_tag++;
                if (n_iss < 4096) begin
                    iss_cyc[n_iss] = cyc;
                    iss_pix[n_iss] = trig_p;
                end
                last_iss_cyc = cyc;
                if (n_done == 1 && f2_ch < 0) f2_ch = int'(bus.o_ch_sel);
                n_iss++;
            end
            after_acc = bus.o_lb_shift;
            if (bus.o_lb_shift) begin
                trig_p = n_shift % NPIX;
                n_shift++;
                if (n_done > 0 && acc_after_done < 0) acc_after_done = cyc;
            end
            if (bus.o_res_valid) begin
                idx = n_res % NPF;
                if (bus.o_res_ch !== CW_D'(idx % DEF_CO)) bad_tag++;
                if (bus.o_res_x !== XW_D'((idx / DEF_CO) % NX)) bad_tag++;
                if (bus.o_res_y !== YW_D'(idx / (DEF_CO * NX))) bad_tag++;
                if (n_res < n_iss && n_res < 4096) begin
                    if (cyc - iss_cyc[n_res] != MAC_LAT) bad_lat++;
                    p = iss_pix[n_res];
                    if (p >= 0) begin
                        px_x[p] = int'(bus.o_res_x);
                        px_y[p] = int'(bus.o_res_y);
                    end
                end else begin
                    bad_lat++;
                end
                if (n_done == 1 && f2_x < 0) begin
                    f2_x = int'(bus.o_res_x);
                    f2_y = int'(bus.o_res_y);
                end
                n_res++;
            end
            if (bus.o_done) begin
                if (n_done == 0) d1_cyc = cyc;
                n_done++;
                done_cyc = cyc;
            end
        end
    endtask

    task automatic do_reset();
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        mon_clear();
    endtask

    task automatic run_frame(input int pct, input int nf);
        int k;
        mon_clear();
        k = 0;
        while (n_done < nf && k < 8000 * nf) begin
            step((pct >= 100) ? 1'b1 : ($urandom_range(99) < pct), 1'b0);
            k++;
        end
        checks++;
        if (n_done < nf) begin
            errors++;
            $display("FAIL frame_timeout done=%0d want=%0d", n_done, nf);
        end
    endtask

    task automatic test_reset();
        do_reset();
        step(1'b0, 1'b0);
        checks++;
        if (outs() !== {1'b1, 18'b0}) begin
            errors++;
            $display("FAIL reset_outs got=%h want=%h", outs(), {1'b1, 18'b0});
        end
        step(1'b1, 1'b0);
        checks++;
        if (bus.o_lb_shift !== 1'b1 || bus.o_issue !== 1'b0) begin
            errors++;
            $display("FAIL reset_first_accept shift=%b issue=%b want 1 0",
                     bus.o_lb_shift, bus.o_issue);
        end
    endtask

    task automatic test_full_frame();
        do_reset();
        run_frame(100, 1);
        checks++;
        if (n_shift !== NPIX) begin
            errors++;
            $display("FAIL full_shifts got=%0d want=%0d", n_shift, NPIX);
        end
        checks++;
        if (n_iss !== NPF) begin
            errors++;
            $display("FAIL full_issues got=%0d want=%0d", n_iss, NPF);
        end
        checks++;
        if (n_res !== NPF) begin
            errors++;
            $display("FAIL full_results got=%0d want=%0d", n_res, NPF);
        end
        checks++;
        if (done_cyc - last_iss_cyc !== MAC_LAT + 1) begin
            errors++;
            $display("FAIL full_done_lat got=%0d want=%0d",
                     done_cyc - last_iss_cyc, MAC_LAT + 1);
        end
        repeat (4) step(1'b0, 1'b0);
        checks++;
        if (n_done !== 1) begin
            errors++;
            $display("FAIL full_done_count got=%0d want=1", n_done);
        end
        checks++;
        if (bad_tag !== 0 || bad_lat !== 0 || bad_acc !== 0) begin
            errors++;
            $display("FAIL full_order tag=%0d lat=%0d acc=%0d want 0 0 0",
                     bad_tag, bad_lat, bad_acc);
        end
    endtask

    task automatic test_first_window();
        int k;
        do_reset();
        k = 0;
        while (n_shift < 117 && k < 400) begin
            step(1'b1, 1'b0);
            k++;
        end
        for (int c = 0; c < 3; c++) begin
            step(1'b1, 1'b0);
            checks++;
            if ({bus.o_issue, bus.o_ch_sel, bus.o_ready, bus.o_lb_shift}
                !== {1'b1, CW_D'(c), 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL win_issue%0d got iss=%b ch=%0d rdy=%b sh=%b want 1 %0d 0 0",
                         c, bus.o_issue, bus.o_ch_sel, bus.o_ready, bus.o_lb_shift, c);
            end
        end
        for (int c = 0; c < 3; c++) begin
            step(1'b1, 1'b0);
            checks++;
            if ({bus.o_res_valid, bus.o_res_ch, bus.o_res_x, bus.o_res_y}
                !== {1'b1, CW_D'(c), XW_D'(0), YW_D'(0)}) begin
                errors++;
                $display("FAIL win_res%0d got v=%b ch=%0d x=%0d y=%0d want 1 %0d 0 0",
                         c, bus.o_res_valid, bus.o_res_ch, bus.o_res_x, bus.o_res_y, c);
            end
        end
    endtask

    task automatic test_row_boundary();
        int wbad;
        do_reset();
        run_frame(100, 1);
        wbad = 0;
        for (int p = 0; p < NPIX; p++)
            if (px_iss[p] != ((p / DEF_IX >= DEF_KY - 1) && (p % DEF_IX >= DEF_KX - 1)))
                wbad++;
        checks++;
        if (wbad !== 0) begin
            errors++;
            $display("FAIL row_window_map got=%0d bad pixels want=0", wbad);
        end
        checks++;
        if (px_iss[140] || px_iss[141] || px_iss[142] || px_iss[143]) begin
            errors++;
            $display("FAIL row5_fill got=%b%b%b%b want=0000",
                     px_iss[140], px_iss[141], px_iss[142], px_iss[143]);
        end
        checks++;
        if (!px_iss[139] || px_x[139] !== 23 || px_y[139] !== 0) begin
            errors++;
            $display("FAIL row4_col27 got iss=%b x=%0d y=%0d want 1 23 0",
                     px_iss[139], px_x[139], px_y[139]);
        end
        checks++;
        if (!px_iss[144] || px_x[144] !== 0 || px_y[144] !== 1) begin
            errors++;
            $display("FAIL row5_col4 got iss=%b x=%0d y=%0d want 1 0 1",
                     px_iss[144], px_x[144], px_y[144]);
        end
    endtask

    task automatic test_random_gaps();
        do_reset();
        run_frame(50, 1);
        checks++;
        if (n_shift !== NPIX || n_iss !== NPF || n_res !== NPF) begin
            errors++;
            $display("FAIL gap_counts got sh=%0d iss=%0d res=%0d want %0d %0d %0d",
                     n_shift, n_iss, n_res, NPIX, NPF, NPF);
        end
        checks++;
        if (bad_tag !== 0 || bad_lat !== 0 || bad_acc !== 0) begin
            errors++;
            $display("FAIL gap_order tag=%0d lat=%0d acc=%0d want 0 0 0",
                     bad_tag, bad_lat, bad_acc);
        end
    endtask

    task automatic test_reset_mid();
        int k;
        int stale;
        do_reset();
        k = 0;
        while (!(bus.o_issue === 1'b1 && bus.o_ch_sel === CW_D'(1)) && k < 400) begin
            step(1'b1, 1'b0);
            k++;
        end
        reset = 1'b1;
        step(1'b0, 1'b0);
        checks++;
        if (outs() !== {1'b1, 18'b0}) begin
            errors++;
            $display("FAIL rst_issue_outs got=%h want=%h", outs(), {1'b1, 18'b0});
        end
        stale = 0;
        repeat (MAC_LAT + 2) begin
            step(1'b0, 1'b0);
            if (bus.o_res_valid) stale++;
        end
        checks++;
        if (stale !== 0) begin
            errors++;
            $display("FAIL rst_issue_stale got=%0d want=0", stale);
        end

        do_reset();
        k = 0;
        while (n_iss < NPF && k < 4000) begin
            step(1'b1, 1'b0);
            k++;
        end
        step(1'b1, 1'b0);
        checks++;
        if (bus.o_issue !== 1'b0 || bus.o_ready !== 1'b0) begin
            errors++;
            $display("FAIL drain_entry got iss=%b rdy=%b want 0 0",
                     bus.o_issue, bus.o_ready);
        end
        reset = 1'b1;
        step(1'b0, 1'b0);
        checks++;
        if (outs() !== {1'b1, 18'b0}) begin
            errors++;
            $display("FAIL rst_drain_outs got=%h want=%h", outs(), {1'b1, 18'b0});
        end
        stale = 0;
        repeat (MAC_LAT + 2) begin
            step(1'b0, 1'b0);
            if (bus.o_res_valid || bus.o_done) stale++;
        end
        checks++;
        if (stale !== 0) begin
            errors++;
            $display("FAIL rst_drain_stale got=%0d want=0", stale);
        end

        run_frame(100, 1);
        checks++;
        if (n_iss !== NPF || n_res !== NPF || bad_tag !== 0 || bad_lat !== 0) begin
            errors++;
            $display("FAIL rst_refresh got iss=%0d res=%0d tag=%0d lat=%0d want %0d %0d 0 0",
                     n_iss, n_res, bad_tag, bad_lat, NPF, NPF);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        run_frame(100, 2);
        checks++;
        if (acc_after_done - d1_cyc !== 1) begin
            errors++;
            $display("FAIL b2b_first_accept got=%0d want=1", acc_after_done - d1_cyc);
        end
        checks++;
        if (f2_ch !== 0 || f2_x !== 0 || f2_y !== 0) begin
            errors++;
            $display("FAIL b2b_restart got ch=%0d x=%0d y=%0d want 0 0 0",
                     f2_ch, f2_x, f2_y);
        end
        checks++;
        if (n_shift !== 2 * NPIX || n_iss !== 2 * NPF || n_res !== 2 * NPF) begin
            errors++;
            $display("FAIL b2b_counts got sh=%0d iss=%0d res=%0d want %0d %0d %0d",
                     n_shift, n_iss, n_res, 2 * NPIX, 2 * NPF, 2 * NPF);
        end
        repeat (4) step(1'b0, 1'b0);
        checks++;
        if (n_done !== 2 || bad_tag !== 0 || bad_lat !== 0) begin
            errors++;
            $display("FAIL b2b_done got done=%0d tag=%0d lat=%0d want 2 0 0",
                     n_done, bad_tag, bad_lat);
        end
    endtask

    initial begin
        bus.i_valid = 1'b0;
        mon_clear();
        test_reset();
        test_full_frame();
        test_first_window();
        test_row_boundary();
        test_random_gaps();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
